// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor signal bundle for the branch resolve queue.
// The slave modport belongs to the queue; the master modport belongs to its environment.
interface branch_resolve_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = 2
);
  logic                  alloc_valid;
  logic [DATA_WIDTH-1:0] alloc_pc;
  logic                  alloc_pred;
  logic [DATA_WIDTH-1:0] alloc_target;
  logic                  alloc_ready;
  logic                  resolve_valid;
  logic                  resolve_taken;
  logic [DATA_WIDTH-1:0] resolve_target;
  logic                  flush;
  logic                  update;
  logic                  actually_taken;
  logic [DATA_WIDTH-1:0] resolved_pc;
  logic                  mispredict;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [PTR_WIDTH:0]    count;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred, alloc_target,
    output resolve_valid, resolve_taken, resolve_target, flush,
    input  alloc_ready, update, actually_taken, resolved_pc,
    input  mispredict, redirect_pc, count
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred, alloc_target,
    input  resolve_valid, resolve_taken, resolve_target, flush,
    output alloc_ready, update, actually_taken, resolved_pc,
    output mispredict, redirect_pc, count
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches: fetch allocates, execute resolves the oldest,
// the result feeds the predictor update and a registered mispredict/redirect.
module branch_resolve_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input logic                    clk,
  input logic                    rstn,
  branch_resolve_queue_if.slave  bus
);

  function automatic logic is_mispredict(input logic pred, input logic taken,
                                         input logic [DATA_WIDTH-1:0] pred_tgt,
                                         input logic [DATA_WIDTH-1:0] act_tgt);
    return (pred != taken) || (taken && (pred_tgt != act_tgt));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] correct_pc(input logic taken,
                                                       input logic [DATA_WIDTH-1:0] act_tgt,
                                                       input logic [DATA_WIDTH-1:0] pc);
    return taken ? act_tgt : pc + DATA_WIDTH'(4);
  endfunction

  logic [DATA_WIDTH-1:0] pc_mem   [DEPTH];
  logic                  pred_mem [DEPTH];
  logic [DATA_WIDTH-1:0] tgt_mem  [DEPTH];

  logic [PTR_WIDTH-1:0]  head_q, tail_q;
  logic [PTR_WIDTH:0]    count_q, count_nxt;

  logic                  alloc_ready_p0, res_fire_p0, mis_p0, enq_fire_p0;
  logic [DATA_WIDTH-1:0] head_pc_p0;

  logic                  update_p1, mispredict_p1, taken_p1;
  logic [DATA_WIDTH-1:0] resolved_pc_p1, redirect_pc_p1;

  // Stage p0: decide this cycle's resolve/enqueue against the current head entry
  assign head_pc_p0     = pc_mem[head_q];
  assign alloc_ready_p0 = (count_q != (PTR_WIDTH+1)'(DEPTH));
  assign res_fire_p0    = bus.resolve_valid && (count_q != '0) && !bus.flush;
  assign mis_p0         = res_fire_p0 && is_mispredict(pred_mem[head_q], bus.resolve_taken,
                                                       tgt_mem[head_q], bus.resolve_target);
  // An alloc alongside a mispredict is on the wrong path and is dropped
  assign enq_fire_p0    = bus.alloc_valid && alloc_ready_p0 && !bus.flush && !mis_p0;

  always_comb begin
    count_nxt = count_q;
    case ({enq_fire_p0, res_fire_p0})
      2'b10:   count_nxt = count_q + (PTR_WIDTH+1)'(1);
      2'b01:   count_nxt = count_q - (PTR_WIDTH+1)'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq_fire_p0) begin
      pc_mem[tail_q]   <= bus.alloc_pc;
      pred_mem[tail_q] <= bus.alloc_pred;
      tgt_mem[tail_q]  <= bus.alloc_target;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.flush || mis_p0) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (res_fire_p0) head_q <= head_q + PTR_WIDTH'(1);
      if (enq_fire_p0) tail_q <= tail_q + PTR_WIDTH'(1);
      count_q <= count_nxt;
    end
  end

  // Stage p1: registered predictor update and redirect
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      update_p1      <= 1'b0;
      mispredict_p1  <= 1'b0;
      taken_p1       <= 1'b0;
      resolved_pc_p1 <= '0;
      redirect_pc_p1 <= '0;
    end else begin
      update_p1     <= res_fire_p0;
      mispredict_p1 <= mis_p0;
      if (res_fire_p0) begin
        taken_p1       <= bus.resolve_taken;
        resolved_pc_p1 <= head_pc_p0;
      end
      if (mis_p0)
        redirect_pc_p1 <= correct_pc(bus.resolve_taken, bus.resolve_target, head_pc_p0);
    end
  end

  assign bus.alloc_ready    = alloc_ready_p0;
  assign bus.count          = count_q;
  assign bus.update         = update_p1;
  assign bus.mispredict     = mispredict_p1;
  assign bus.actually_taken = taken_p1;
  assign bus.resolved_pc    = resolved_pc_p1;
  assign bus.redirect_pc    = redirect_pc_p1;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios then random traffic,
// checked every cycle against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int PW    = 2;

  typedef struct {
    logic [DW-1:0] pc;
    logic          pred;
    logic [DW-1:0] tgt;
  } ent_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus ();

  branch_resolve_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  ent_t          mq[$];
  logic          e_update, e_mis, e_taken;
  logic [DW-1:0] e_rpc, e_redir;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("update", 64'(bus.update), 64'(e_update));
    chk("mispredict", 64'(bus.mispredict), 64'(e_mis));
    chk("actually_taken", 64'(bus.actually_taken), 64'(e_taken));
    chk("resolved_pc", 64'(bus.resolved_pc), 64'(e_rpc));
    chk("redirect_pc", 64'(bus.redirect_pc), 64'(e_redir));
    chk("count", 64'(bus.count), 64'(mq.size()));
  endtask

  task automatic model_reset();
    mq.delete();
    e_update = 0; e_mis = 0; e_taken = 0; e_rpc = '0; e_redir = '0;
  endtask

  // One clock: drive inputs after the falling edge, check ready, model the edge, check results.
  task automatic step(input logic av, input logic [DW-1:0] apc, input logic ap,
                      input logic [DW-1:0] atg, input logic rv, input logic rt,
                      input logic [DW-1:0] rtg, input logic fl);
    logic ready, mis;
    ent_t e;
    @(negedge clk);
    bus.alloc_valid = av; bus.alloc_pc = apc; bus.alloc_pred = ap; bus.alloc_target = atg;
    bus.resolve_valid = rv; bus.resolve_taken = rt; bus.resolve_target = rtg; bus.flush = fl;
    #1;
    ready = (mq.size() < DEPTH);
    chk("alloc_ready", 64'(bus.alloc_ready), 64'(ready));
    mis = 0;
    e_update = 0;
    e_mis = 0;
    if (fl) begin
      mq.delete();
    end else begin
      if (rv && mq.size() > 0) begin
        e = mq.pop_front();
        mis = (e.pred != rt) || (rt && e.tgt != rtg);
        e_update = 1; e_taken = rt; e_rpc = e.pc;
        if (mis) begin
          e_mis = 1;
          e_redir = rt ? rtg : e.pc + 32'd4;
          mq.delete();
        end
      end
      if (!mis && av && ready) mq.push_back('{pc: apc, pred: ap, tgt: atg});
    end
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic alloc(input logic [DW-1:0] pc, input logic pred, input logic [DW-1:0] tgt);
    step(1, pc, pred, tgt, 0, 0, '0, 0);
  endtask

  task automatic resolve(input logic taken, input logic [DW-1:0] tgt);
    step(0, '0, 0, '0, 1, taken, tgt, 0);
  endtask

  initial begin
    bus.alloc_valid = 0; bus.alloc_pc = '0; bus.alloc_pred = 0; bus.alloc_target = '0;
    bus.resolve_valid = 0; bus.resolve_taken = 0; bus.resolve_target = '0; bus.flush = 0;
    model_reset();

    // Reset state
    #12;
    chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    chk_outputs();
    @(negedge clk); rstn = 1'b1;
    idle();

    // Single not-taken branch, correctly predicted
    alloc(32'h100, 0, 32'h200);
    resolve(0, '0);
    chk("t2_rpc", 64'(bus.resolved_pc), 64'h100);
    idle();

    // Fill, drop when full, wrap pointers
    alloc(32'h10, 0, '0); alloc(32'h20, 0, '0); alloc(32'h30, 0, '0); alloc(32'h40, 0, '0);
    chk("t3_full_count", 64'(bus.count), 64'd4);
    alloc(32'h50, 0, '0);
    resolve(0, '0); resolve(0, '0);
    alloc(32'h60, 0, '0); alloc(32'h70, 0, '0);
    resolve(0, '0); resolve(0, '0); resolve(0, '0); resolve(0, '0);
    chk("t3_last_rpc", 64'(bus.resolved_pc), 64'h70);
    // Full with a same-cycle pop still refuses the alloc
    alloc(32'h80, 0, '0); alloc(32'h84, 0, '0); alloc(32'h88, 0, '0); alloc(32'h8c, 0, '0);
    step(1, 32'h90, 0, '0, 1, 0, '0, 0);
    resolve(0, '0); resolve(0, '0); resolve(0, '0);
    idle();

    // Direction mispredict with a wrong-path alloc in the same cycle
    alloc(32'h100, 1, 32'h180); alloc(32'h104, 0, '0);
    step(1, 32'h500, 0, '0, 1, 0, '0, 0);
    chk("t4_redirect", 64'(bus.redirect_pc), 64'h104);
    idle();

    // Target mispredict
    alloc(32'h200, 1, 32'h300);
    resolve(1, 32'h340);
    chk("t5_redirect", 64'(bus.redirect_pc), 64'h340);
    idle();

    // Flush beats resolve and alloc; resolve while empty is ignored
    alloc(32'h400, 0, '0); alloc(32'h404, 1, 32'h800);
    step(1, 32'h408, 0, '0, 1, 0, '0, 1);
    resolve(1, 32'h900);
    idle();

    // Random traffic with mispredicts and flushes
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, {$urandom_range(0, 32'h3fff_ffff), 2'b00},
           1'($urandom_range(0, 1)), {24'h0, 4'($urandom_range(0, 3)), 4'h0},
           $urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)),
           {24'h0, 4'($urandom_range(0, 3)), 4'h0}, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset mid-operation drops everything immediately
    alloc(32'hA0, 0, '0); alloc(32'hA4, 0, '0); resolve(0, '0);
    @(negedge clk);
    bus.alloc_valid = 0; bus.resolve_valid = 0; bus.flush = 0;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk("async_rst_ready", 64'(bus.alloc_ready), 64'd1);
    chk_outputs();
    @(negedge clk); rstn = 1'b1;
    idle();
    alloc(32'hC0, 1, 32'hD0);
    resolve(1, 32'hD0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
